// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared constants, field offsets and state encoding for pwm_capture
package pwm_capture_pkg;

    localparam int CNT_W = 12;

    // bRData field offsets
    localparam int HIGH_LSB  = 0;
    localparam int PER_LSB   = 12;
    localparam int OVF_BIT   = 30;
    localparam int VALID_BIT = 31;

    // bWData bit indices
    localparam int EN_BIT  = 0;
    localparam int CLR_BIT = 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// rtl/pwm_capture_sync_edge.sv - input synchronizer with one-cycle delayed copy and rising-edge detect
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sd;

    // shift the raw input through the synchronizer chain; r_sd lags the synchronized output by one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_sd   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_sd   <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_sd;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of a PWM input, bus-readable status
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bSel,
    input  logic        bWrite,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    input  logic        pwmIn
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt_p;
    logic [CNT_W-1:0]   r_cnt_h;
    logic [CNT_W-1:0]   r_high;
    logic [CNT_W-1:0]   r_period;
    logic               r_valid;
    logic               r_ovf;

    logic               w_s;
    logic               w_rise;
    logic               w_wr;
    logic               w_en;
    logic               w_clear;
    logic               w_cnt_load;
    logic               w_cnt_inc;
    logic               w_capture;
    logic               w_timeout;
    logic [31:0]        w_rdata;
    logic               w_unused_wdata;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pwmIn),
        .o_s     (w_s),
        .o_rise  (w_rise)
    );

    assign w_wr           = bSel & bWrite;
    assign w_en           = bWData[EN_BIT];
    assign w_unused_wdata = ^bWData[31:2];

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and per-cycle actions; clear beats disable beats capture/timeout
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        if (w_wr && bWData[CLR_BIT]) begin
            w_clear     = 1'b1;
            w_state_nxt = w_en ? ARM : IDLE;
        end else if (w_wr && !w_en) begin
            w_state_nxt = IDLE;
        end else if (w_wr && (r_state == IDLE)) begin
            w_state_nxt = ARM;
        end else begin
            case (r_state)
                ARM: begin
                    if (w_rise) begin
                        w_state_nxt = MEAS;
                        w_cnt_load  = 1'b1;
                    end
                end
                MEAS: begin
                    if (w_rise) begin
                        w_cnt_load = 1'b1;
                        w_capture  = 1'b1;
                    end else if (r_cnt_p == CNT_MAX) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                IDLE:    ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // period and high-time counters; restart at 1 on each rising edge, frozen outside MEAS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_p <= '0;
            r_cnt_h <= '0;
        end else if (w_clear) begin
            r_cnt_p <= '0;
            r_cnt_h <= '0;
        end else if (w_cnt_load) begin
            r_cnt_p <= CNT_W'(1);
            r_cnt_h <= CNT_W'(1);
        end else if (w_cnt_inc) begin
            r_cnt_p <= r_cnt_p + CNT_W'(1);
            r_cnt_h <= r_cnt_h + CNT_W'(w_s);
        end
    end

    // result registers: capture on rise, saturate on timeout, zero on clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_clear) begin
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_capture) begin
            r_high   <= r_cnt_h;
            r_period <= r_cnt_p;
            r_valid  <= 1'b1;
        end else if (w_timeout) begin
            r_high   <= w_s ? CNT_MAX : '0;
            r_period <= CNT_MAX;
            r_valid  <= 1'b1;
            r_ovf    <= 1'b1;
        end
    end

    // read data packing straight from registers
    always_comb begin
        w_rdata                        = '0;
        w_rdata[HIGH_LSB +: CNT_W]     = r_high;
        w_rdata[PER_LSB  +: CNT_W]     = r_period;
        w_rdata[OVF_BIT]               = r_ovf;
        w_rdata[VALID_BIT]             = r_valid;
    end

    assign bRData = w_rdata;

endmodule
